// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles and
// saturating stall/flush event counters.
module id_ex_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regWrite,
  input  logic             id_memRead,
  input  logic             id_memWrite,
  input  logic             id_memToReg,
  input  logic             id_aluSrc,
  input  logic             id_branch,
  input  logic [3:0]       id_aluOp,
  input  logic             ex_flush,
  output logic             id_ex_valid,
  output logic [XLEN-1:0]  id_ex_pc,
  output logic [XLEN-1:0]  id_ex_rs1_data,
  output logic [XLEN-1:0]  id_ex_rs2_data,
  output logic [XLEN-1:0]  id_ex_imm,
  output logic [4:0]       id_ex_reg_rs1,
  output logic [4:0]       id_ex_reg_rs2,
  output logic [4:0]       id_ex_rd,
  output logic             id_ex_regWrite,
  output logic             id_ex_memRead,
  output logic             id_ex_memWrite,
  output logic             id_ex_memToReg,
  output logic             id_ex_aluSrc,
  output logic             id_ex_branch,
  output logic [3:0]       id_ex_aluOp,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             r_valid;
  logic [XLEN-1:0]  r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic             r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src, r_branch;
  logic [3:0]       r_alu_op;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_load_use;
  logic w_bubble;
  logic w_ctrl_en;

  // Both sources compared regardless of format; x0 is never a hazard source.
  assign w_load_use = id_valid & r_valid & r_mem_read & (r_rd != 5'd0) &
                      ((r_rd == id_rs1) | (r_rd == id_rs2));
  assign w_bubble   = ex_flush | w_load_use;
  assign w_ctrl_en  = id_valid & ~w_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_op     <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      // Datapath fields always follow ID; only valid/control are forced for bubbles.
      r_pc         <= id_pc;
      r_rs1_data   <= id_rs1_data;
      r_rs2_data   <= id_rs2_data;
      r_imm        <= id_imm;
      r_rs1        <= id_rs1;
      r_rs2        <= id_rs2;
      r_rd         <= id_rd;
      r_valid      <= w_ctrl_en;
      r_reg_write  <= w_ctrl_en & id_regWrite;
      r_mem_read   <= w_ctrl_en & id_memRead;
      r_mem_write  <= w_ctrl_en & id_memWrite;
      r_mem_to_reg <= w_ctrl_en & id_memToReg;
      r_alu_src    <= w_ctrl_en & id_aluSrc;
      r_branch     <= w_ctrl_en & id_branch;
      r_alu_op     <= w_ctrl_en ? id_aluOp : 4'd0;
      if (w_load_use && !ex_flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (ex_flush && id_valid && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // A taken branch overrides the stall so the redirect proceeds.
  assign pc_write       = ~(w_load_use & ~ex_flush);
  assign if_id_write    = ~(w_load_use & ~ex_flush);

  assign id_ex_valid    = r_valid;
  assign id_ex_pc       = r_pc;
  assign id_ex_rs1_data = r_rs1_data;
  assign id_ex_rs2_data = r_rs2_data;
  assign id_ex_imm      = r_imm;
  assign id_ex_reg_rs1  = r_rs1;
  assign id_ex_reg_rs2  = r_rs2;
  assign id_ex_rd       = r_rd;
  assign id_ex_regWrite = r_reg_write;
  assign id_ex_memRead  = r_mem_read;
  assign id_ex_memWrite = r_mem_write;
  assign id_ex_memToReg = r_mem_to_reg;
  assign id_ex_aluSrc   = r_alu_src;
  assign id_ex_branch   = r_branch;
  assign id_ex_aluOp    = r_alu_op;
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe; a second narrow-counter instance shares the
// stimulus so counter saturation is reachable in a few dozen cycles.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_branch;
  logic [3:0]  id_aluOp;
  logic        ex_flush;

  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_reg_rs1, id_ex_reg_rs2, id_ex_rd;
  logic        id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_memToReg;
  logic        id_ex_aluSrc, id_ex_branch;
  logic [3:0]  id_ex_aluOp;
  logic        pc_write, if_id_write;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_valid;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_reg_rs1, s_reg_rs2, s_rd;
  logic        s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg, s_alu_src, s_branch;
  logic [3:0]  s_alu_op;
  logic        s_pc_write, s_if_id_write;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_branch(id_branch),
    .id_aluOp(id_aluOp), .ex_flush(ex_flush),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
    .id_ex_reg_rs1(id_ex_reg_rs1), .id_ex_reg_rs2(id_ex_reg_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_regWrite(id_ex_regWrite), .id_ex_memRead(id_ex_memRead),
    .id_ex_memWrite(id_ex_memWrite), .id_ex_memToReg(id_ex_memToReg),
    .id_ex_aluSrc(id_ex_aluSrc), .id_ex_branch(id_ex_branch), .id_ex_aluOp(id_ex_aluOp),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_pipe #(.XLEN(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_branch(id_branch),
    .id_aluOp(id_aluOp), .ex_flush(ex_flush),
    .id_ex_valid(s_valid), .id_ex_pc(s_pc),
    .id_ex_rs1_data(s_rs1_data), .id_ex_rs2_data(s_rs2_data), .id_ex_imm(s_imm),
    .id_ex_reg_rs1(s_reg_rs1), .id_ex_reg_rs2(s_reg_rs2), .id_ex_rd(s_rd),
    .id_ex_regWrite(s_reg_write), .id_ex_memRead(s_mem_read),
    .id_ex_memWrite(s_mem_write), .id_ex_memToReg(s_mem_to_reg),
    .id_ex_aluSrc(s_alu_src), .id_ex_branch(s_branch), .id_ex_aluOp(s_alu_op),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-stage instruction; data fields are derived from pc.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic mtr, input logic as,
                       input logic br, input logic [3:0] op);
    id_valid    = v;
    id_pc       = pc;
    id_rs1_data = pc + 32'h1000;
    id_rs2_data = pc + 32'h2000;
    id_imm      = pc + 32'h3000;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_regWrite = rw;
    id_memRead  = mr;
    id_memWrite = mw;
    id_memToReg = mtr;
    id_aluSrc   = as;
    id_branch   = br;
    id_aluOp    = op;
  endtask

  task automatic test_reset();
    ex_flush = 1'b0;
    drive(1'b1, 32'h44, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA);
    rst = 1'b1;
    step();
    step();
    n_total++;
    if (id_ex_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", id_ex_valid);
    else n_pass++;
    n_total++;
    if ({id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_memToReg, id_ex_aluSrc,
         id_ex_branch, id_ex_aluOp} !== 10'd0)
      $display("FAIL reset_ctrl: got %b want 0", {id_ex_regWrite, id_ex_memRead,
               id_ex_memWrite, id_ex_memToReg, id_ex_aluSrc, id_ex_branch, id_ex_aluOp});
    else n_pass++;
    n_total++;
    if ({id_ex_pc, id_ex_rd, id_ex_reg_rs1, id_ex_reg_rs2} !== 47'd0)
      $display("FAIL reset_data: got pc=%h rd=%0d want 0", id_ex_pc, id_ex_rd);
    else n_pass++;
    n_total++;
    if ({pc_write, if_id_write} !== 2'b11)
      $display("FAIL reset_write_en: got %b want 11", {pc_write, if_id_write});
    else n_pass++;
    n_total++;
    if ({stall_cnt, flush_cnt} !== 32'd0)
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    // add x3, x1, x2
    drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    #1;
    n_total++;
    if (pc_write !== 1'b1) $display("FAIL pass_pc_write: got %b want 1", pc_write);
    else n_pass++;
    step();
    n_total++;
    if ({id_ex_valid, id_ex_rd, id_ex_reg_rs1, id_ex_reg_rs2, id_ex_regWrite}
        !== {1'b1, 5'd3, 5'd1, 5'd2, 1'b1})
      $display("FAIL pass_fields: got v=%b rd=%0d rs1=%0d rs2=%0d rw=%b want 1/3/1/2/1",
               id_ex_valid, id_ex_rd, id_ex_reg_rs1, id_ex_reg_rs2, id_ex_regWrite);
    else n_pass++;
    n_total++;
    if ({id_ex_pc, id_ex_rs1_data, id_ex_imm} !== {32'h100, 32'h1100, 32'h3100})
      $display("FAIL pass_data: got pc=%h rs1d=%h imm=%h want 100/1100/3100",
               id_ex_pc, id_ex_rs1_data, id_ex_imm);
    else n_pass++;
    n_total++;
    if ({id_ex_memRead, id_ex_aluOp} !== 5'd0)
      $display("FAIL pass_ctrl: got mr=%b op=%h want 0/0", id_ex_memRead, id_ex_aluOp);
    else n_pass++;
  endtask

  task automatic test_load_use();
    // lw x5, then sub x6, x5, x7
    drive(1'b1, 32'h104, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b1, 32'h108, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
    #1;
    n_total++;
    if ({pc_write, if_id_write} !== 2'b00)
      $display("FAIL lu_stall: got %b want 00", {pc_write, if_id_write});
    else n_pass++;
    step();
    n_total++;
    if ({id_ex_valid, id_ex_regWrite, id_ex_memRead} !== 3'b000)
      $display("FAIL lu_bubble: got %b want 000", {id_ex_valid, id_ex_regWrite, id_ex_memRead});
    else n_pass++;
    n_total++;
    if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt);
    else n_pass++;
    n_total++;
    if (pc_write !== 1'b1) $display("FAIL lu_release: got %b want 1", pc_write);
    else n_pass++;
    step();
    n_total++;
    if ({id_ex_valid, id_ex_reg_rs1, id_ex_rd, id_ex_aluOp} !== {1'b1, 5'd5, 5'd6, 4'h1})
      $display("FAIL lu_enter: got v=%b rs1=%0d rd=%0d op=%h want 1/5/6/1",
               id_ex_valid, id_ex_reg_rs1, id_ex_rd, id_ex_aluOp);
    else n_pass++;
    // rs2-side match also stalls: lw x9 then add x4, x1, x9
    drive(1'b1, 32'h10C, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b1, 32'h110, 5'd1, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    #1;
    n_total++;
    if (pc_write !== 1'b0) $display("FAIL lu_rs2: got %b want 0", pc_write);
    else n_pass++;
    step();
    n_total++;
    if (stall_cnt !== 16'd2) $display("FAIL lu_rs2_cnt: got %0d want 2", stall_cnt);
    else n_pass++;
    step();
  endtask

  task automatic test_x0_load();
    drive(1'b1, 32'h200, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b1, 32'h204, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
    #1;
    n_total++;
    if ({pc_write, if_id_write} !== 2'b11)
      $display("FAIL x0_no_stall: got %b want 11", {pc_write, if_id_write});
    else n_pass++;
    step();
    n_total++;
    if ({id_ex_valid, id_ex_rd, stall_cnt} !== {1'b1, 5'd8, 16'd2})
      $display("FAIL x0_pass: got v=%b rd=%0d cnt=%0d want 1/8/2",
               id_ex_valid, id_ex_rd, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    drive(1'b1, 32'h304, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    ex_flush = 1'b1;
    #1;
    n_total++;
    if ({pc_write, if_id_write} !== 2'b11)
      $display("FAIL fl_write_en: got %b want 11", {pc_write, if_id_write});
    else n_pass++;
    step();
    n_total++;
    if ({id_ex_valid, id_ex_regWrite, id_ex_aluSrc, id_ex_branch, id_ex_aluOp} !== 8'd0)
      $display("FAIL fl_bubble: got %b want 0", {id_ex_valid, id_ex_regWrite,
               id_ex_aluSrc, id_ex_branch, id_ex_aluOp});
    else n_pass++;
    n_total++;
    if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0})
      $display("FAIL fl_cnt: got flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
    else n_pass++;
    // Flush of an invalid ID slot does not count.
    drive(1'b0, 32'h308, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    ex_flush = 1'b0;
    n_total++;
    if (flush_cnt !== 16'd1) $display("FAIL fl_invalid: got %0d want 1", flush_cnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 32'h400, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++;
    if ({id_ex_valid, id_ex_memWrite, id_ex_aluOp, flush_cnt} !== 22'd0)
      $display("FAIL mid_reset: got v=%b mw=%b op=%h fl=%0d want 0",
               id_ex_valid, id_ex_memWrite, id_ex_aluOp, flush_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0;
    // lw x5, 0(x5) held in ID: alternates load and stall every two cycles.
    drive(1'b1, 32'h500, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 19; i++) begin
      step();
      step();
    end
    n_total++;
    if (stall_cnt !== 16'd19) $display("FAIL sat_wide: got %0d want 19", stall_cnt);
    else n_pass++;
    n_total++;
    if (s_stall_cnt !== 4'hF) $display("FAIL sat_narrow: got %h want f", s_stall_cnt);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    ex_flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    test_reset();
    test_pass_through();
    test_load_use();
    test_x0_load();
    test_flush_priority();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
